// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter:
// FSM states, grant encoding and wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    // Wide enough for WAIT-1 with WAIT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: req[0]=CPU, req[1]=DBG, last_grant in,
// gnt out. FAIR!=0 alternates on ties, FAIR==0 favours CPU.
module arb_rr2
    import mem_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt
);

    always_comb begin
        gnt = GNT_CPU;
        unique case (1'b1)
            (req[0] & req[1]):
                gnt = (FAIR != 0) ? ~last_grant : GNT_CPU;
            (req[1] & ~req[0]):
                gnt = GNT_DBG;
            default:
                gnt = GNT_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between CPU and debug ports.
// Ports: clk/reset, cpu_* and dbg_* requesters, mem_* memory side.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2,
    parameter int FAIR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_adr,
    input  logic [DW-1:0] dbg_wd,
    output logic [DW-1:0] dbg_rd,
    output logic          dbg_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             gnt;
    logic             last_grant;
    logic             pick;
    logic             we_q;
    logic             any_req;

    assign any_req = cpu_req | dbg_req;

    arb_rr2 #(
        .FAIR(FAIR)
    ) u_pick (
        .req       ({dbg_req, cpu_req}),
        .last_grant(last_grant),
        .gnt       (pick)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= GNT_CPU;
            last_grant <= GNT_DBG;
            we_q       <= 1'b0;
            mem_adr    <= '0;
            mem_wd     <= '0;
            cpu_rd     <= '0;
            dbg_rd     <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        cnt        <= CNT_INIT;
                        if (pick == GNT_DBG) begin
                            we_q    <= dbg_we;
                            mem_adr <= dbg_adr;
                            mem_wd  <= dbg_wd;
                        end else begin
                            we_q    <= cpu_we;
                            mem_adr <= cpu_adr;
                            mem_wd  <= cpu_wd;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    // mem_rd is valid in the last ACCESS
                    // cycle, so it lands in rd for DONE.
                    if (cnt == '0 && !we_q) begin
                        if (gnt == GNT_CPU) cpu_rd <= mem_rd;
                        else                dbg_rd <= mem_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = (state == ACCESS);
    // Strobe only on the first ACCESS cycle.
    assign mem_we    = mem_en & we_q & (cnt == CNT_INIT);
    assign cpu_ack   = (state == DONE) & (gnt == GNT_CPU);
    assign dbg_ack   = (state == DONE) & (gnt == GNT_DBG);
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Runs a FAIR=1 instance and a FAIR=0 instance on shared stimulus.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WAIT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_adr = '0;
    logic [DW-1:0] cpu_wd = '0;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_adr = '0;
    logic [DW-1:0] dbg_wd = '0;
    logic [DW-1:0] mem_rd = '0;

    logic [DW-1:0] cpu_rd, dbg_rd, mem_wd;
    logic [AW-1:0] mem_adr;
    logic          cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we;

    logic [DW-1:0] cpu_rd0, dbg_rd0, mem_wd0;
    logic [AW-1:0] mem_adr0;
    logic          cpu_ack0, cpu_stall0, dbg_ack0, mem_en0, mem_we0;

    int n_chk = 0;
    int n_err = 0;
    int we_pulses = 0;
    int w0;
    int dbg0_acks;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .WAIT(WAIT), .FAIR(1)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
        .dbg_rd(dbg_rd), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .WAIT(WAIT), .FAIR(0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd0), .cpu_ack(cpu_ack0),
        .cpu_stall(cpu_stall0),
        .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
        .dbg_rd(dbg_rd0), .dbg_ack(dbg_ack0),
        .mem_en(mem_en0), .mem_we(mem_we0),
        .mem_adr(mem_adr0), .mem_wd(mem_wd0),
        .mem_rd(mem_rd)
    );

    always @(negedge clk) if (mem_we === 1'b1) we_pulses++;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst cpu_rd", cpu_rd, 0);
        chk("rst dbg_rd", dbg_rd, 0);
        chk("rst acks", {cpu_ack, dbg_ack}, 0);
        chk("rst mem_en/we", {mem_en, mem_we}, 0);
        chk("rst mem_adr", mem_adr, 0);
        chk("rst mem_wd", mem_wd, 0);
        reset = 1'b0;

        // 1: reset during second ACCESS cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_adr = 32'h80; cpu_wd = 32'hDEAD0001;
        w0 = we_pulses;
        tick();
        chk("t1 we N+1", {mem_en, mem_we}, 2'b11);
        chk("t1 adr N+1", mem_adr, 32'h80);
        tick();
        chk("t1 we N+2", {mem_en, mem_we}, 2'b10);
        reset = 1'b1;
        tick();
        chk("t1 after rst", {mem_en, mem_we, cpu_ack}, 0);
        cpu_req = 1'b0; cpu_we = 1'b0; reset = 1'b0;
        tick();
        chk("t1 no ack", {mem_en, cpu_ack}, 0);
        chk("t1 one strobe", we_pulses - w0, 1);

        // 2: CPU read
        mem_rd = 32'hCAFEF00D;
        cpu_req = 1'b1; cpu_adr = 32'h100;
        #1;
        chk("t2 stall N", {cpu_stall, cpu_ack}, 2'b10);
        tick();
        chk("t2 stall N+1", {cpu_stall, mem_en}, 2'b11);
        tick();
        chk("t2 stall N+2", {cpu_stall, mem_en, cpu_ack}, 3'b110);
        tick();
        chk("t2 ack N+3", {cpu_ack, cpu_stall, dbg_ack}, 3'b100);
        chk("t2 cpu_rd", cpu_rd, 32'hCAFEF00D);
        cpu_req = 1'b0;
        tick();
        chk("t2 N+4", {cpu_ack, mem_en}, 0);
        chk("t2 rd hold", cpu_rd, 32'hCAFEF00D);
        chk("t2 dbg_rd", dbg_rd, 0);

        // 3: debug write
        dbg_req = 1'b1; dbg_we = 1'b1;
        dbg_adr = 32'h40; dbg_wd = 32'h12345678;
        w0 = we_pulses;
        tick();
        chk("t3 we N+1", mem_we, 1);
        chk("t3 adr", mem_adr, 32'h40);
        chk("t3 wd", mem_wd, 32'h12345678);
        tick();
        chk("t3 N+2", {mem_en, mem_we}, 2'b10);
        chk("t3 adr N+2", mem_adr, 32'h40);
        tick();
        chk("t3 ack", {dbg_ack, cpu_ack}, 2'b10);
        chk("t3 dbg_rd kept", dbg_rd, 0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        tick();
        chk("t3 N+4", dbg_ack, 0);
        chk("t3 one strobe", we_pulses - w0, 1);
        chk("t3 cpu_rd", cpu_rd, 32'hCAFEF00D);

        // 4: both held, round robin (last grant was DBG)
        mem_rd = 32'hA5A50000;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k % 4 == 3)
                chk($sformatf("t4 ack k%0d", k),
                    {cpu_ack, dbg_ack},
                    (k % 8 == 3) ? 2'b10 : 2'b01);
            if (k == 7) chk("t4 dbg_rd", dbg_rd, 32'hA5A50000);
            if (k == 15) begin cpu_req = 1'b0; dbg_req = 1'b0; end
            tick();
        end

        // 5: both held, fixed priority instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rd = 32'h0BADBEEF;
        cpu_req = 1'b1; dbg_req = 1'b1;
        dbg0_acks = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (dbg_ack0) dbg0_acks++;
            if (k % 4 == 3)
                chk($sformatf("t5 cpu ack k%0d", k), cpu_ack0, 1);
            if (k == 3) chk("t5 cpu_rd0", cpu_rd0, 32'h0BADBEEF);
            if (k == 15) begin cpu_req = 1'b0; dbg_req = 1'b0; end
            tick();
        end
        chk("t5 no dbg ack", dbg0_acks, 0);
        chk("t5 dbg_rd0", dbg_rd0, 0);

        // 6: back-to-back CPU reads
        mem_rd = 32'h11111111;
        cpu_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            if (k == 3) begin
                chk("t6 ack1", cpu_ack, 1);
                chk("t6 rd1", cpu_rd, 32'h11111111);
                mem_rd = 32'h22222222;
            end
            if (k == 4)
                chk("t6 idle", {mem_en, cpu_ack, cpu_stall}, 3'b001);
            if (k == 5) chk("t6 access2", mem_en, 1);
            if (k == 6) chk("t6 no early ack", cpu_ack, 0);
            if (k == 7) begin
                chk("t6 ack2", cpu_ack, 1);
                chk("t6 rd2", cpu_rd, 32'h22222222);
                cpu_req = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
